// File: rtl/id2ex_pipe_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: control-bit positions and default widths.
package id2ex_pkg;
  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int M_BRANCH     = 2;
  localparam int M_MEMREAD    = 1;
  localparam int M_MEMWRITE   = 0;
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUSRC    = 2;
  localparam int EX_ALUOP_LSB = 0;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int WB_W_DEF   = 2;
  localparam int M_W_DEF    = 3;
  localparam int EX_W_DEF   = 4;
  localparam int CNT_W_DEF  = 16;
endpackage

// File: rtl/id2ex_pipe_reg_if.sv
// ID-to-EX bundle: ID-side controls/operands in, registered EX-side copies, hazard and counters out.
interface id2ex_pipe_reg_if
  import id2ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int WB_W   = WB_W_DEF,
  parameter int M_W    = M_W_DEF,
  parameter int EX_W   = EX_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              valid_i;
  logic              stall_i;
  logic              flush_i;
  logic [WB_W-1:0]   WB;
  logic [M_W-1:0]    M;
  logic [EX_W-1:0]   EX;
  logic [REG_AW-1:0] RD1, RD2, RS_addr, RT_addr;
  logic [DATA_W-1:0] RS, RT, Immediately;

  logic              valid_o;
  logic [WB_W-1:0]   WB_o;
  logic [M_W-1:0]    M_o;
  logic [EX_W-1:0]   EX_o;
  logic [REG_AW-1:0] RD1_o, RD2_o, RS_addr_o, RT_addr_o;
  logic [DATA_W-1:0] RS_o, RT_o, Immediately_o;
  logic              hazard_stall_o;
  logic [CNT_W-1:0]  instr_cnt_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output valid_i, stall_i, flush_i, WB, M, EX, RD1, RD2, RS_addr, RT_addr, RS, RT, Immediately,
    input  valid_o, WB_o, M_o, EX_o, RD1_o, RD2_o, RS_addr_o, RT_addr_o, RS_o, RT_o, Immediately_o,
    input  hazard_stall_o, instr_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  valid_i, stall_i, flush_i, WB, M, EX, RD1, RD2, RS_addr, RT_addr, RS, RT, Immediately,
    output valid_o, WB_o, M_o, EX_o, RD1_o, RD2_o, RS_addr_o, RT_addr_o, RS_o, RT_o, Immediately_o,
    output hazard_stall_o, instr_cnt_o, bubble_cnt_o
  );
endinterface

// File: rtl/id2ex_pipe_reg_sat_counter.sv
// Saturating up-counter: synchronous active-low clear, sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/id2ex_pipe_reg.sv
// ID/EX pipeline register with stall-hold, flush-to-bubble and a load-use bubble inserter.
// One-cycle load latency; hazard_stall_o is combinational and freezes PC and IF/ID.
module id2ex_pipe_reg
  import id2ex_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int WB_W      = WB_W_DEF,
  parameter int M_W       = M_W_DEF,
  parameter int EX_W      = EX_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int HAZARD_EN = 1
) (
  input logic             clk,
  input logic             rst_n,
  id2ex_pipe_reg_if.slave bus
);
  logic hz;
  logic bubble;
  logic load;

  // A load in EX whose destination is read by the instruction sitting in ID.
  assign hz = (HAZARD_EN != 0) && bus.valid_o && bus.M_o[M_MEMREAD] &&
              (bus.RT_addr_o != '0) && bus.valid_i &&
              ((bus.RT_addr_o == bus.RS_addr) || (bus.RT_addr_o == bus.RT_addr));

  assign bus.hazard_stall_o = hz && !bus.flush_i;

  assign bubble = bus.flush_i || (!bus.stall_i && hz);
  assign load   = !bus.flush_i && !bus.stall_i && !hz;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      bus.valid_o       <= 1'b0;
      bus.WB_o          <= '0;
      bus.M_o           <= '0;
      bus.EX_o          <= '0;
      bus.RD1_o         <= '0;
      bus.RD2_o         <= '0;
      bus.RS_addr_o     <= '0;
      bus.RT_addr_o     <= '0;
      bus.RS_o          <= '0;
      bus.RT_o          <= '0;
      bus.Immediately_o <= '0;
    end else if (load) begin
      bus.valid_o       <= bus.valid_i;
      // An empty slot still carries its fields but must not write regs or memory.
      bus.WB_o          <= bus.valid_i ? bus.WB : '0;
      bus.M_o           <= bus.valid_i ? bus.M  : '0;
      bus.EX_o          <= bus.EX;
      bus.RD1_o         <= bus.RD1;
      bus.RD2_o         <= bus.RD2;
      bus.RS_addr_o     <= bus.RS_addr;
      bus.RT_addr_o     <= bus.RT_addr;
      bus.RS_o          <= bus.RS;
      bus.RT_o          <= bus.RT;
      bus.Immediately_o <= bus.Immediately;
    end
  end

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (load && bus.valid_i),
    .count (bus.instr_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble),
    .count (bus.bubble_cnt_o)
  );
endmodule

// File: tb/tb_id2ex_pipe_reg.sv
// Directed bench: a 16-bit-counter DUT and a 2-bit-counter DUT share one stimulus stream.
module tb_id2ex_pipe_reg;
  import id2ex_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  id2ex_pipe_reg_if #(.CNT_W(16)) bi ();
  id2ex_pipe_reg_if #(.CNT_W(2))  bs ();

  assign bs.valid_i     = bi.valid_i;
  assign bs.stall_i     = bi.stall_i;
  assign bs.flush_i     = bi.flush_i;
  assign bs.WB          = bi.WB;
  assign bs.M           = bi.M;
  assign bs.EX          = bi.EX;
  assign bs.RD1         = bi.RD1;
  assign bs.RD2         = bi.RD2;
  assign bs.RS_addr     = bi.RS_addr;
  assign bs.RT_addr     = bi.RT_addr;
  assign bs.RS          = bi.RS;
  assign bs.RT          = bi.RT;
  assign bs.Immediately = bi.Immediately;

  id2ex_pipe_reg #(.CNT_W(16), .HAZARD_EN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bi));
  id2ex_pipe_reg #(.CNT_W(2),  .HAZARD_EN(1)) dut_small (.clk(clk), .rst_n(rst_n), .bus(bs));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with busy-looking inputs
    rst_n          = 1'b0;
    bi.valid_i     = 1'b1;
    bi.stall_i     = 1'b0;
    bi.flush_i     = 1'b0;
    bi.WB          = 2'b11;
    bi.M           = 3'b111;
    bi.EX          = 4'hF;
    bi.RD1         = 5'd3;
    bi.RD2         = 5'd4;
    bi.RS_addr     = 5'd5;
    bi.RT_addr     = 5'd6;
    bi.RS          = 32'hFFFF_FFFF;
    bi.RT          = 32'hCAFE_0001;
    bi.Immediately = 32'h0000_0010;
    tick();
    tick();
    chk("rst_valid", 64'(bi.valid_o), 64'd0);
    chk("rst_wb", 64'(bi.WB_o), 64'd0);
    chk("rst_m", 64'(bi.M_o), 64'd0);
    chk("rst_rs", 64'(bi.RS_o), 64'd0);
    chk("rst_imm", 64'(bi.Immediately_o), 64'd0);
    chk("rst_instr", 64'(bi.instr_cnt_o), 64'd0);
    chk("rst_bubble", 64'(bi.bubble_cnt_o), 64'd0);

    // First load after reset
    rst_n   = 1'b1;
    bi.WB   = 2'b00;
    bi.M    = 3'b000;
    bi.RS   = 32'h1234_5678;
    tick();
    chk("load_rs", 64'(bi.RS_o), 64'h1234_5678);
    chk("load_valid", 64'(bi.valid_o), 64'd1);
    chk("load_rt", 64'(bi.RT_o), 64'hCAFE_0001);
    chk("load_instr", 64'(bi.instr_cnt_o), 64'd1);

    // Stall holds everything
    bi.WB = 2'b11;
    bi.RS = 32'h0000_AAAA;
    tick();
    chk("wb_load", 64'(bi.WB_o), 64'd3);
    chk("instr_2", 64'(bi.instr_cnt_o), 64'd2);
    bi.stall_i = 1'b1;
    bi.WB      = 2'b01;
    bi.RS      = 32'h0000_5555;
    tick();
    bi.RS      = 32'h0000_7777;
    bi.RD1     = 5'd17;
    tick();
    tick();
    chk("stall_wb", 64'(bi.WB_o), 64'd3);
    chk("stall_rs", 64'(bi.RS_o), 64'h0000_AAAA);
    chk("stall_rd1", 64'(bi.RD1_o), 64'd3);
    chk("stall_instr", 64'(bi.instr_cnt_o), 64'd2);
    chk("stall_bubble", 64'(bi.bubble_cnt_o), 64'd0);

    // Flush overrides stall
    bi.flush_i = 1'b1;
    tick();
    chk("flush_valid", 64'(bi.valid_o), 64'd0);
    chk("flush_m", 64'(bi.M_o), 64'd0);
    chk("flush_wb", 64'(bi.WB_o), 64'd0);
    chk("flush_rs", 64'(bi.RS_o), 64'd0);
    chk("flush_bubble", 64'(bi.bubble_cnt_o), 64'd1);
    chk("flush_instr", 64'(bi.instr_cnt_o), 64'd2);
    bi.flush_i = 1'b0;
    bi.stall_i = 1'b0;

    // Load-use: lw $8 then a reader of $8
    bi.M       = 3'b010;
    bi.WB      = 2'b11;
    bi.RT_addr = 5'd8;
    bi.RS_addr = 5'd1;
    tick();
    chk("lw_m", 64'(bi.M_o), 64'd2);
    chk("lw_rt", 64'(bi.RT_addr_o), 64'd8);
    chk("small_instr_sat3", 64'(bs.instr_cnt_o), 64'd3);
    bi.RS_addr = 5'd8;
    bi.RT_addr = 5'd9;
    bi.M       = 3'b000;
    bi.WB      = 2'b10;
    bi.RS      = 32'h0000_DEAD;
    #1;
    chk("lu_hazard", 64'(bi.hazard_stall_o), 64'd1);
    tick();
    chk("lu_bubble_valid", 64'(bi.valid_o), 64'd0);
    chk("lu_bubble_cnt", 64'(bi.bubble_cnt_o), 64'd2);
    chk("lu_instr_hold", 64'(bi.instr_cnt_o), 64'd3);
    chk("lu_hazard_drop", 64'(bi.hazard_stall_o), 64'd0);
    tick();
    chk("lu_dep_valid", 64'(bi.valid_o), 64'd1);
    chk("lu_dep_rsaddr", 64'(bi.RS_addr_o), 64'd8);
    chk("lu_dep_rs", 64'(bi.RS_o), 64'h0000_DEAD);
    chk("lu_dep_instr", 64'(bi.instr_cnt_o), 64'd4);
    chk("lu_dep_hazard", 64'(bi.hazard_stall_o), 64'd0);
    chk("lu_bubble_once", 64'(bi.bubble_cnt_o), 64'd2);

    // No false hazard: lw to $0
    bi.M       = 3'b010;
    bi.RT_addr = 5'd0;
    bi.RS_addr = 5'd0;
    tick();
    chk("lw0_m", 64'(bi.M_o), 64'd2);
    chk("lw0_hazard", 64'(bi.hazard_stall_o), 64'd0);

    // No false hazard: sw with matching RT
    bi.M       = 3'b001;
    bi.RT_addr = 5'd7;
    bi.RS_addr = 5'd7;
    tick();
    chk("sw_m", 64'(bi.M_o), 64'd1);
    chk("sw_hazard", 64'(bi.hazard_stall_o), 64'd0);
    chk("sw_instr", 64'(bi.instr_cnt_o), 64'd6);

    // Flush coinciding with a load-use hazard
    bi.M       = 3'b010;
    bi.RT_addr = 5'd10;
    tick();
    bi.M       = 3'b000;
    bi.RS_addr = 5'd3;
    bi.flush_i = 1'b1;
    #1;
    chk("fh_hazard_masked", 64'(bi.hazard_stall_o), 64'd0);
    tick();
    chk("fh_bubble_cnt", 64'(bi.bubble_cnt_o), 64'd3);
    chk("fh_valid", 64'(bi.valid_o), 64'd0);
    chk("fh_instr", 64'(bi.instr_cnt_o), 64'd7);
    bi.flush_i = 1'b0;
    tick();
    chk("fh_reload_instr", 64'(bi.instr_cnt_o), 64'd8);
    chk("fh_reload_bubble", 64'(bi.bubble_cnt_o), 64'd3);

    // Empty slot: fields copied but side-effect controls zeroed
    bi.valid_i = 1'b0;
    bi.WB      = 2'b11;
    bi.M       = 3'b111;
    bi.RS      = 32'h0000_BEEF;
    tick();
    chk("inv_valid", 64'(bi.valid_o), 64'd0);
    chk("inv_wb", 64'(bi.WB_o), 64'd0);
    chk("inv_m", 64'(bi.M_o), 64'd0);
    chk("inv_rs", 64'(bi.RS_o), 64'h0000_BEEF);
    chk("inv_instr", 64'(bi.instr_cnt_o), 64'd8);

    // 2-bit counters saturate rather than wrap
    chk("small_instr_sat", 64'(bs.instr_cnt_o), 64'd3);
    chk("small_bubble_sat", 64'(bs.bubble_cnt_o), 64'd3);

    // Reset in the middle of a stall clears everything
    bi.valid_i = 1'b1;
    bi.stall_i = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst2_small_instr", 64'(bs.instr_cnt_o), 64'd0);
    chk("rst2_small_bubble", 64'(bs.bubble_cnt_o), 64'd0);
    chk("rst2_instr", 64'(bi.instr_cnt_o), 64'd0);
    chk("rst2_rs", 64'(bi.RS_o), 64'd0);
    chk("rst2_valid", 64'(bi.valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
